main_memory_ctrl: RTL and testbench
===================================

MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bits per word.
REQ-002 Parameter ADDRESS_BITS, default 32: word address width.
REQ-003 Parameter MSG_BITS, default 4: bus message width.
REQ-004 Parameter OFFSET_BITS, default 2: log2 of words per line; line width L_WIDTH = (1<<OFFSET_BITS)*DATA_WIDTH.
REQ-005 Parameter INDEX_BITS, default 8: log2 of lines stored.
REQ-006 Parameter LATENCY, default 4, legal range >= 1: request-accept to response cycles.
REQ-007 clock  in  1: single clock; all logic on rising edge.
REQ-008 reset  in  1: synchronous, active-high.
REQ-009 cachehier2mem_msg  in  MSG_BITS: request message from L2.
REQ-010 cachehier2mem_address  in  ADDRESS_BITS: request word address.
REQ-011 cachehier2mem_data  in  L_WIDTH: write-back line data.
REQ-012 mem2cachehier_msg  out  MSG_BITS: response message to L2.
REQ-013 mem2cachehier_address  out  ADDRESS_BITS: response address.
REQ-014 mem2cachehier_data  out  L_WIDTH: response line data.

Function
REQ-015 Message codes: NO_REQ=0, R_REQ=1, WB_REQ=2, FLUSH=3, MEM_RESP=10; all other codes are ignored in IDLE.
REQ-016 Storage: 2^INDEX_BITS lines of L_WIDTH; line index = address[OFFSET_BITS +: INDEX_BITS]; upper address bits are ignored (aliasing).
REQ-017 FSM states: IDLE, WAIT, RESP.
REQ-018 IDLE: on a sampled R_REQ, WB_REQ or FLUSH, latch msg, address and data, load counter with LATENCY-1, go to WAIT.
REQ-019 WAIT: decrement the counter each cycle; at zero go to RESP.
REQ-020 WAIT->RESP edge: WB_REQ/FLUSH write the latched line into the array; R_REQ reads the indexed line into the response register.
REQ-021 Latency: a request sampled at edge N produces mem2cachehier_msg=MEM_RESP visible after edge N+LATENCY.
REQ-022 RESP: drive MEM_RESP, the latched address, and line data (read data for R_REQ, the written line for WB_REQ/FLUSH).
REQ-023 RESP handshake: hold outputs stable until cachehier2mem_msg==NO_REQ is sampled, then go to IDLE with msg=NO_REQ the next cycle.
REQ-024 In RESP, a request message other than NO_REQ holds the state; it is never accepted as a new request.
REQ-025 Request dropped to NO_REQ during WAIT: the transaction still completes (write committed); RESP lasts exactly one cycle.
REQ-026 A new request is accepted only in IDLE, giving a minimum of LATENCY+2 cycles between accepts.
REQ-027 In IDLE and WAIT: mem2cachehier_msg=NO_REQ, address=0, data=0.
REQ-028 Write then read of the same line returns the written data, with no bypass needed since transactions are serialized.

Reset
REQ-029 When reset is sampled high: state=IDLE, counter=0, latched registers and all outputs set to 0.
REQ-030 Reset during WAIT discards the pending transaction; no array write occurs.
REQ-031 Reset does not alter the array contents; contents before the first write are undefined (benches preload through a write-back).

Structure
REQ-032 Message codes and FSM state encoding are defined in a shared package or include used by the cache blocks.
REQ-033 The storage array is one sub-module, mem_line_array: one synchronous read/write port, L_WIDTH x 2^INDEX_BITS, no reset.
REQ-034 The counter width is log2(LATENCY)+1 bits.

Verification
REQ-035 Defaults: WB_REQ, addr 0x40, data 0x44443333_22221111_00000000_DEADBEEF, held until MEM_RESP -> MEM_RESP exactly 4 cycles after accept, addr echoed; drop to NO_REQ -> NO_REQ the next cycle.
REQ-036 R_REQ addr 0x41 after REQ-035 -> MEM_RESP after 4 cycles, data equals the REQ-035 line (same index 0x10).
REQ-037 R_REQ held 10 cycles in RESP -> outputs stable all 10 cycles; no second transaction starts.
REQ-038 WB_REQ addr 0x80 data all-ones, reset pulsed in WAIT cycle 2; then R_REQ 0x80 -> old line contents, not all-ones.
REQ-039 Request code 7 in IDLE -> ignored, outputs stay NO_REQ; aliasing: WB_REQ 0x400 then R_REQ 0x0 -> same line (INDEX_BITS=8).
REQ-040 LATENCY=1 build: R_REQ -> MEM_RESP visible after the next edge; back-to-back requests accepted every 3 cycles.

Source files
------------

// File: rtl/main_memory_ctrl_pkg.sv
// Shared definitions for the cache hierarchy / main memory bus:
// message codes, controller FSM state encoding, and a small decode helper.
package main_memory_ctrl_pkg;

    // Bus message codes (carried in MSG_BITS-wide fields)
    localparam int MSG_NO_REQ   = 0;
    localparam int MSG_R_REQ    = 1;
    localparam int MSG_WB_REQ   = 2;
    localparam int MSG_FLUSH    = 3;
    localparam int MSG_MEM_RESP = 10;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // True for messages that carry a line to be stored (write-back and flush)
    function automatic logic is_write_msg(input int msg);
        return (msg == MSG_WB_REQ) || (msg == MSG_FLUSH);
    endfunction

endpackage

// File: rtl/main_memory_ctrl_mem_line_array.sv
// Line storage for the main memory model: one synchronous read/write port,
// registered read data, no reset on the contents.
module mem_line_array #(
    parameter int LINE_WIDTH = 128,
    parameter int INDEX_BITS = 8
) (
    input  logic                  clock,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [INDEX_BITS-1:0] i_index,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic [LINE_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [LINE_WIDTH-1:0] r_lines [0:DEPTH-1];
    logic [LINE_WIDTH-1:0] r_rdata;

    // Single port: write the addressed line, or capture it into the read register
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_lines[i_index] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_lines[i_index];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/main_memory_ctrl.sv
// Fixed-latency main memory controller behind the L2. Accepts one request at
// a time in IDLE, waits LATENCY cycles, commits the write or reads the line,
// then holds MEM_RESP until the requester returns to NO_REQ.
import main_memory_ctrl_pkg::*;

module main_memory_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int MSG_BITS     = 4,
    parameter int OFFSET_BITS  = 2,
    parameter int INDEX_BITS   = 8,
    parameter int LATENCY      = 4,
    localparam int L_WIDTH     = (1 << OFFSET_BITS) * DATA_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [MSG_BITS-1:0]     cachehier2mem_msg,
    input  logic [ADDRESS_BITS-1:0] cachehier2mem_address,
    input  logic [L_WIDTH-1:0]      cachehier2mem_data,
    output logic [MSG_BITS-1:0]     mem2cachehier_msg,
    output logic [ADDRESS_BITS-1:0] mem2cachehier_address,
    output logic [L_WIDTH-1:0]      mem2cachehier_data
);

    localparam int CNT_W = $clog2(LATENCY) + 1;

    mem_state_e                r_state;
    mem_state_e                w_state_next;
    logic [CNT_W-1:0]          r_count;
    logic [MSG_BITS-1:0]       r_msg;
    logic [ADDRESS_BITS-1:0]   r_addr;
    logic [L_WIDTH-1:0]        r_data;

    logic                      w_req_valid;
    logic                      w_accept;
    logic                      w_wait_done;
    logic                      w_is_write;
    logic                      w_is_read;
    logic                      w_mem_we;
    logic                      w_mem_re;
    logic [INDEX_BITS-1:0]     w_index;
    logic [L_WIDTH-1:0]        w_rd_data;

    // Request decode and the single commit point at the end of WAIT
    always_comb begin
        w_req_valid = (cachehier2mem_msg == MSG_BITS'(MSG_R_REQ))  ||
                      (cachehier2mem_msg == MSG_BITS'(MSG_WB_REQ)) ||
                      (cachehier2mem_msg == MSG_BITS'(MSG_FLUSH));
        w_accept    = (r_state == ST_IDLE) && w_req_valid;
        w_wait_done = (r_state == ST_WAIT) && (r_count == '0);
        w_is_write  = is_write_msg(int'(r_msg));
        w_is_read   = (r_msg == MSG_BITS'(MSG_R_REQ));
        // A reset landing on the commit edge must discard the transaction
        w_mem_we    = w_wait_done && w_is_write && !reset;
        w_mem_re    = w_wait_done && w_is_read  && !reset;
        w_index     = r_addr[OFFSET_BITS +: INDEX_BITS];
    end

    mem_line_array #(
        .LINE_WIDTH (L_WIDTH),
        .INDEX_BITS (INDEX_BITS)
    ) u_mem_line_array (
        .clock   (clock),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_index (w_index),
        .i_wdata (r_data),
        .o_rdata (w_rd_data)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request latch and latency counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_msg   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_count <= CNT_W'(LATENCY - 1);
            r_msg   <= cachehier2mem_msg;
            r_addr  <= cachehier2mem_address;
            r_data  <= cachehier2mem_data;
        end else if ((r_state == ST_WAIT) && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_state_next = ST_WAIT;
            ST_WAIT: if (w_wait_done) w_state_next = ST_RESP;
            ST_RESP: if (cachehier2mem_msg == MSG_BITS'(MSG_NO_REQ))
                         w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Response outputs: quiet except in RESP, where read data comes from the array
    always_comb begin
        mem2cachehier_msg     = '0;
        mem2cachehier_address = '0;
        mem2cachehier_data    = '0;
        if (r_state == ST_RESP) begin
            mem2cachehier_msg     = MSG_BITS'(MSG_MEM_RESP);
            mem2cachehier_address = r_addr;
            mem2cachehier_data    = w_is_read ? w_rd_data : r_data;
        end
    end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl: a default LATENCY=4 instance and a
// LATENCY=1 instance sharing clock and reset.
module tb_main_memory_ctrl;

    logic         clock;
    logic         reset;

    logic [3:0]   req_msg;
    logic [31:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   rsp_msg;
    logic [31:0]  rsp_addr;
    logic [127:0] rsp_data;

    logic [3:0]   req1_msg;
    logic [31:0]  req1_addr;
    logic [127:0] req1_data;
    logic [3:0]   rsp1_msg;
    logic [31:0]  rsp1_addr;
    logic [127:0] rsp1_data;

    int n_vec = 0;
    int n_bad = 0;
    int k;

    localparam logic [127:0] D1   = 128'h44443333_22221111_00000000_DEADBEEF;
    localparam logic [127:0] D2   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] D3   = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [127:0] D4   = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] D5   = 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0;
    localparam logic [127:0] ONES = {128{1'b1}};

    main_memory_ctrl u_dut (
        .clock                 (clock),
        .reset                 (reset),
        .cachehier2mem_msg     (req_msg),
        .cachehier2mem_address (req_addr),
        .cachehier2mem_data    (req_data),
        .mem2cachehier_msg     (rsp_msg),
        .mem2cachehier_address (rsp_addr),
        .mem2cachehier_data    (rsp_data)
    );

    main_memory_ctrl #(.LATENCY(1)) u_dut1 (
        .clock                 (clock),
        .reset                 (reset),
        .cachehier2mem_msg     (req1_msg),
        .cachehier2mem_address (req1_addr),
        .cachehier2mem_data    (req1_data),
        .mem2cachehier_msg     (rsp1_msg),
        .mem2cachehier_address (rsp1_addr),
        .mem2cachehier_data    (rsp1_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a request on the default instance, let it be accepted, then count
    // edges after the accept edge until MEM_RESP appears (bounded).
    task automatic run_req(input logic [3:0] m, input logic [31:0] a, input logic [127:0] d,
                           input bit drop_early, output int cycles);
        req_msg  = m;
        req_addr = a;
        req_data = d;
        step();
        if (drop_early) req_msg = 4'd0;
        cycles = 0;
        while (rsp_msg !== 4'd10 && cycles < 20) begin
            step();
            cycles++;
        end
    endtask

    task automatic release_req(input string tag);
        req_msg = 4'd0;
        step();
        check_val(tag, {124'd0, rsp_msg}, 128'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_msg   = '0; req_addr  = '0; req_data  = '0;
        req1_msg  = '0; req1_addr = '0; req1_data = '0;
        step();
        step();
        check_val("reset_msg",  {124'd0, rsp_msg}, 128'd0);
        check_val("reset_addr", {96'd0, rsp_addr}, 128'd0);
        check_val("reset_data", rsp_data, 128'd0);
        check_val("reset_msg1", {124'd0, rsp1_msg}, 128'd0);
        reset = 1'b0;
        step();

        // Write-back to 0x40, held through RESP
        run_req(4'd2, 32'h40, D1, 1'b0, k);
        check_val("wb_latency", 128'(k), 128'd4);
        check_val("wb_msg",  {124'd0, rsp_msg}, 128'd10);
        check_val("wb_addr", {96'd0, rsp_addr}, 128'h40);
        check_val("wb_data", rsp_data, D1);
        step();
        check_val("wb_hold_msg", {124'd0, rsp_msg}, 128'd10);
        release_req("wb_release");

        // Read 0x41 (same index 0x10), held 10 cycles in RESP
        run_req(4'd1, 32'h41, '0, 1'b0, k);
        check_val("rd_latency", 128'(k), 128'd4);
        check_val("rd_addr", {96'd0, rsp_addr}, 128'h41);
        check_val("rd_data", rsp_data, D1);
        for (int i = 0; i < 10; i++) begin
            step();
            check_val($sformatf("hold%0d_msg", i),  {124'd0, rsp_msg}, 128'd10);
            check_val($sformatf("hold%0d_addr", i), {96'd0, rsp_addr}, 128'h41);
            check_val($sformatf("hold%0d_data", i), rsp_data, D1);
        end
        release_req("rd_release");

        // Unknown code 7 in IDLE is ignored
        req_msg  = 4'd7;
        req_addr = 32'h40;
        for (int i = 0; i < 6; i++) begin
            step();
            check_val($sformatf("ign%0d_msg", i), {124'd0, rsp_msg}, 128'd0);
        end
        req_msg = 4'd0;
        step();

        // Request dropped during WAIT still completes, RESP lasts one cycle
        run_req(4'd2, 32'h44, D4, 1'b1, k);
        check_val("drop_latency", 128'(k), 128'd4);
        check_val("drop_data", rsp_data, D4);
        step();
        check_val("drop_one_cycle", {124'd0, rsp_msg}, 128'd0);
        run_req(4'd1, 32'h44, '0, 1'b0, k);
        check_val("drop_readback", rsp_data, D4);
        release_req("drop_release");

        // Reset in WAIT discards a pending write-back
        run_req(4'd2, 32'h80, D2, 1'b0, k);
        release_req("pre80_release");
        req_msg  = 4'd2;
        req_addr = 32'h80;
        req_data = ONES;
        step();
        step();
        reset   = 1'b1;
        req_msg = 4'd0;
        step();
        reset = 1'b0;
        check_val("rstwait_msg",  {124'd0, rsp_msg}, 128'd0);
        check_val("rstwait_addr", {96'd0, rsp_addr}, 128'd0);
        for (int i = 0; i < 6; i++) step();
        check_val("rstwait_noresp", {124'd0, rsp_msg}, 128'd0);
        run_req(4'd1, 32'h80, '0, 1'b0, k);
        check_val("rstwait_latency", 128'(k), 128'd4);
        check_val("rstwait_old_line", rsp_data, D2);
        release_req("rstwait_release");

        // Aliasing: 0x400 and 0x0 share index 0
        run_req(4'd2, 32'h400, D3, 1'b0, k);
        release_req("alias_wb_release");
        run_req(4'd1, 32'h0, '0, 1'b0, k);
        check_val("alias_addr", {96'd0, rsp_addr}, 128'h0);
        check_val("alias_data", rsp_data, D3);
        release_req("alias_release");

        // LATENCY=1 instance: response after the next edge, accepts 3 cycles apart
        req1_msg  = 4'd2;
        req1_addr = 32'h8;
        req1_data = D5;
        step();
        check_val("l1_wb_wait",  {124'd0, rsp1_msg}, 128'd0);
        step();
        check_val("l1_wb_resp",  {124'd0, rsp1_msg}, 128'd10);
        check_val("l1_wb_data",  rsp1_data, D5);
        req1_msg = 4'd0;
        step();
        check_val("l1_idle",     {124'd0, rsp1_msg}, 128'd0);
        req1_msg = 4'd1;
        step();
        check_val("l1_rd_wait",  {124'd0, rsp1_msg}, 128'd0);
        step();
        check_val("l1_rd_resp",  {124'd0, rsp1_msg}, 128'd10);
        check_val("l1_rd_addr",  {96'd0, rsp1_addr}, 128'h8);
        check_val("l1_rd_data",  rsp1_data, D5);
        req1_msg = 4'd0;
        step();
        check_val("l1_release",  {124'd0, rsp1_msg}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
